stack_mem_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single-port synchronous data memory between the stack CPU's load/store port and a debug/testbench port. It serialises the two requesters, latches the winning request, drives the memory for one cycle and returns read data with a one-cycle `ready` pulse. It sits between `cpu` and the data memory instance; the debug port lets benches preload data and inspect results while the CPU runs.

---
 rtl/stack_mem_arbiter_pkg.sv | 31 +++
 rtl/stack_mem_arbiter_arb_select.sv | 63 ++++++
 rtl/stack_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_stack_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_arbiter_pkg.sv
// rtl/stack_mem_arbiter_pkg.sv - shared encodings and defaults for the stack data-memory arbiter
//
// Contents:
//   state_t          arbiter FSM states (ST_IDLE, ST_GRANT, ST_RESP)
//   owner_t          owner of the access in flight (OWN_CPU, OWN_DBG)
//   DEF_ADDR_W       default memory word-address width
//   DEF_DATA_W       default data word width
//   other_owner()    returns the port that is not the given owner
// Optional feature macro used by the importers: STACK_MEM_ARB_RR_EN

package stack_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef logic owner_t;

  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_DBG = 1'b1;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  function automatic owner_t other_owner(input owner_t owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/stack_mem_arbiter_arb_select.sv
// rtl/stack_mem_arbiter_arb_select.sv - 2-way grant selector (arb_select) for the stack data-memory arbiter
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   cpu_req  in   CPU port request
//   dbg_req  in   debug port request
//   take     in   1 on the cycle the FSM leaves IDLE with the current grant
//   grant    out  selected owner (combinational); only meaningful when a request is present
// Macro: STACK_MEM_ARB_RR_EN selects round-robin ties; otherwise the CPU has fixed priority.

module stack_mem_arbiter_arb_select
  import stack_mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   take,
  output owner_t grant
);

`ifdef STACK_MEM_ARB_RR_EN

  // Remembers who was granted last. Resetting to "debug" makes the CPU
  // the winner of the first tie after reset.
  owner_t last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_DBG;
    end else if (take) begin
      last_owner <= grant;
    end
  end

  always_comb begin
    grant = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant = other_owner(last_owner);
    end else if (dbg_req) begin
      grant = OWN_DBG;
    end
  end

`else

  // Fixed priority: debug only wins when the CPU is not asking.
  always_comb begin
    grant = OWN_CPU;
    if (!cpu_req && dbg_req) begin
      grant = OWN_DBG;
    end
  end

  // No pointer state in this build; the clock, reset and take strobe are
  // intentionally left without a load.
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, take};

`endif

endmodule

// File: rtl/stack_mem_arbiter.sv
// rtl/stack_mem_arbiter.sv - shares the single-port data memory between the stack CPU and a debug port
//
// Parameters:
//   ADDR_W      memory word-address width
//   DATA_W      data word width
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request (req held until cpu_ready)
//   cpu_ready, cpu_rdata, cpu_stall  CPU completion pulse, read data, pipeline stall
//   dbg_req/we/addr/wdata            debug request (req held until dbg_ready)
//   dbg_ready, dbg_rdata             debug completion pulse, read data
//   mem_en/we/addr/wdata             registered memory command
//   mem_rdata                        registered memory read data (valid the cycle after mem_en)
// Macro: STACK_MEM_ARB_RR_EN enables round-robin tie breaking in the selector.

module stack_mem_arbiter
  import stack_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            state_nx;
  owner_t            owner;
  owner_t            grant;
  logic              take;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp_rd;

  stack_mem_arbiter_arb_select u_arb_select (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .take    (take),
    .grant   (grant)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; 'take' marks the IDLE->GRANT edge that latches the request.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_nx = ST_GRANT;
          take     = 1'b1;
        end
      end
      ST_GRANT: state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Request mux driven by the selector's choice.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // Latched memory command. mem_we/addr/wdata stay put after GRANT so the
  // RESP cycle still knows whether the access was a write; the memory only
  // acts while mem_en is high, so the held values are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_CPU;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take) begin
      owner     <= grant;
      mem_en    <= 1'b1;
      mem_we    <= sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end else if (state == ST_GRANT) begin
      mem_en    <= 1'b0;
    end
  end

  // Responses decode straight from state so an asynchronous reset kills a
  // pending ready pulse at once. Writes return zero rather than whatever
  // the memory put on its read port.
  always_comb begin
    cpu_ready = (state == ST_RESP) && (owner == OWN_CPU);
    dbg_ready = (state == ST_RESP) && (owner == OWN_DBG);
    resp_rd   = !mem_we;
    cpu_rdata = (cpu_ready && resp_rd) ? mem_rdata : '0;
    dbg_rdata = (dbg_ready && resp_rd) ? mem_rdata : '0;
  end

  assign cpu_stall = cpu_req & ~cpu_ready;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// tb/tb_stack_mem_arbiter.sv - self-checking bench for stack_mem_arbiter with a behavioural memory model

module tb_stack_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ready;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  // Physical memory the DUT drives (environment, not the reference).
  logic [DW-1:0] mem [256] = '{default: '0};
  // Reference view of memory contents, updated only from completed requests.
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  // Reference arbitration history: 1 when the debug port was granted last.
  bit            last_dbg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  stack_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ready (dbg_ready),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
  endtask

  // Wait (sampling on falling edges) for any ready pulse; returns cycles waited.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(cpu_ready || dbg_ready) && cyc < 20);
  endtask

  // One isolated access from an idle arbiter: checks latency, data and port isolation.
  task automatic access(input bit port, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int cyc;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wd);
    #1;
    if (!port) check("cpu_stall_same_cycle", cpu_stall, 1);
    wait_ready(cyc);
    exp_rd = we ? '0 : ref_mem[addr];
    check("latency", cyc, 2);
    check("owner_ready", port ? dbg_ready : cpu_ready, 1);
    check("other_ready", port ? cpu_ready : dbg_ready, 0);
    check("owner_rdata", port ? dbg_rdata : cpu_rdata, exp_rd);
    check("other_rdata", port ? cpu_rdata : dbg_rdata, 0);
    if (!port) check("cpu_stall_at_ready", cpu_stall, 0);
    if (we) ref_mem[addr] = wd;
    last_dbg = port;
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int            cyc;
    bit            exp_dbg;
    bit            win;
    bit            rq_we   [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_wd   [2];

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    last_dbg = 1'b1;
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_mem_en", mem_en, 0);
      check("idle_mem_we", mem_we, 0);
      check("idle_readys", {cpu_ready, dbg_ready}, 0);
      check("idle_rdata", cpu_rdata | dbg_rdata, 0);
      check("idle_stall", cpu_stall, 0);
    end

    // CPU write then read-back
    access(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    check("mem_holds_write", mem[8'h10], 32'hDEADBEEF);
    access(1'b0, 1'b0, 8'h10, '0);

    // Debug preload and read while the CPU is idle
    access(1'b1, 1'b1, 8'h04, 32'h00000007);
    access(1'b1, 1'b0, 8'h04, '0);

    // Request changes in flight must not affect the latched access
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h10, 32'hA5A50001);
    @(negedge clk);
    check("inflight_mem_en", mem_en, 1);
    check("inflight_mem_addr", mem_addr, 8'h10);
    drive(1'b0, 1'b1, 1'b1, 8'h20, 32'h5A5A0002);
    @(negedge clk);
    check("inflight_ready", cpu_ready, 1);
    ref_mem[8'h10] = 32'hA5A50001;
    last_dbg = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    access(1'b1, 1'b0, 8'h10, '0);
    access(1'b1, 1'b0, 8'h20, '0);

    // Randomised single-requester traffic against the reference memory
    for (int i = 0; i < 30; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), $urandom);
    end

    // Reset during RESP: ready vanishes immediately, pointer returns to "debug last"
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_ready", cpu_ready, 1);
    rst = 1'b1;
    #1;
    check("reset_kills_ready", cpu_ready, 0);
    check("reset_kills_rdata", cpu_rdata, 0);
    check("reset_mem_en", mem_en, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    last_dbg = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Both ports request continuously; each winner re-presents a new request,
    // after the 4th grant the winner drops and the other is served alone.
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      rq_we[p]   = 1'($urandom_range(0, 1));
      rq_addr[p] = AW'($urandom_range(0, 15));
      rq_wd[p]   = $urandom;
      drive(p[0], 1'b1, rq_we[p], rq_addr[p], rq_wd[p]);
    end
    for (int k = 0; k < 5; k++) begin
      if (cpu_req && dbg_req) begin
`ifdef STACK_MEM_ARB_RR_EN
        exp_dbg = !last_dbg;
`else
        exp_dbg = 1'b0;
`endif
      end else begin
        exp_dbg = dbg_req;
      end
      wait_ready(cyc);
      check("tie_gap", cyc, (k == 0) ? 2 : 3);
      check("tie_winner_dbg", dbg_ready, exp_dbg);
      check("tie_one_ready", cpu_ready & dbg_ready, 0);
      win = exp_dbg;
      check("tie_rdata", win ? dbg_rdata : cpu_rdata,
            rq_we[win] ? '0 : ref_mem[rq_addr[win]]);
      if (rq_we[win]) ref_mem[rq_addr[win]] = rq_wd[win];
      last_dbg = win;
      if (k < 3) begin
        rq_we[win]   = 1'($urandom_range(0, 1));
        rq_addr[win] = AW'($urandom_range(0, 15));
        rq_wd[win]   = $urandom;
        drive(win, 1'b1, rq_we[win], rq_addr[win], rq_wd[win]);
      end else begin
        drive(win, 1'b0, 1'b0, '0, '0);
      end
    end

    // Normal traffic resumes and memory contents agree with the model
    access(1'b0, 1'b0, 8'h10, '0);
    for (int a = 0; a < 16; a++) begin
      access(1'b1, 1'b0, AW'(a), '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
